// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA3 round pipe and its feeder.
package sha3_pkg;

  typedef logic [63:0] lane_t;
  typedef lane_t [4:0] row_t;

  localparam int SHA3_BURST = 16;
  localparam int ROW_W      = $bits(row_t);
  localparam int STATE_W    = 5 * ROW_W;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    WAIT_LOW
  } feeder_state_e;

endpackage

// File: rtl/sha3_state_fifo.sv
// Synchronous FIFO of Keccak state plus tag words; only pointers and count are reset.
module sha3_state_fifo #(
  parameter int W     = 1608,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sha3_burst_feeder.sv
// Queues Keccak states and releases them to the round pipe as fixed-length
// bursts, zero-padding a partial burst once the queue has sat idle too long.
module sha3_burst_feeder #(
  parameter int BURST   = sha3_pkg::SHA3_BURST,
  parameter int DEPTH   = 32,
  parameter int TAG_W   = 8,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [319:0]     ina,
  input  logic [319:0]     inb,
  input  logic [319:0]     inc,
  input  logic [319:0]     ind,
  input  logic [319:0]     ine,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             gimme,
  output logic             sample,
  output logic [319:0]     oa,
  output logic [319:0]     ob,
  output logic [319:0]     oc,
  output logic [319:0]     od,
  output logic [319:0]     oe,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_real
);

  import sha3_pkg::*;

  localparam int WORD_W = STATE_W + TAG_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int SLOT_W = $clog2(BURST);
  localparam int NR_W   = SLOT_W + 1;
  localparam int TMR_W  = $clog2(TIMEOUT + 2);

  feeder_state_e     state, state_nxt;
  logic [SLOT_W-1:0] slot;
  logic [NR_W-1:0]   n_real;
  logic [NR_W-1:0]   slot_nxt;
  logic [TMR_W-1:0]  timer;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              start;
  logic              timed_out;
  logic              load;
  logic              load_real;
  logic [WORD_W-1:0] in_word;
  logic [WORD_W-1:0] head;
  logic [WORD_W-1:0] out_p0;
  logic              sample_p0;
  logic              real_p0;

  function automatic logic [NR_W-1:0] clamp_to_burst(input logic [CNT_W-1:0] c);
    if (c >= CNT_W'(BURST)) return NR_W'(BURST);
    return NR_W'(c);
  endfunction

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] t);
    if (t == TMR_W'(TIMEOUT)) return t;
    return t + 1'b1;
  endfunction

  assign in_word   = {in_tag, ine, ind, inc, inb, ina};
  assign in_ready  = ~full;
  assign push      = in_valid & ~full;
  assign timed_out = (TIMEOUT != 0) && (timer == TMR_W'(TIMEOUT));
  assign start     = gimme & ((count >= CNT_W'(BURST)) | timed_out);
  assign slot_nxt  = NR_W'(slot) + NR_W'(1);

  sha3_state_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (in_word),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= sha3_pkg::IDLE;
    else        state <= state_nxt;
  end

  // load marks an edge that registers a new slot; n_real is fixed at launch so
  // states pushed mid-burst wait for the next one.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_real = 1'b0;
    case (state)
      sha3_pkg::IDLE: begin
        if (start) begin
          state_nxt = sha3_pkg::BURST;
          load      = 1'b1;
          load_real = ~empty;
        end
      end
      sha3_pkg::BURST: begin
        if (slot == SLOT_W'(BURST - 1)) begin
          state_nxt = sha3_pkg::WAIT_LOW;
        end else begin
          load      = 1'b1;
          load_real = (slot_nxt < n_real);
        end
      end
      sha3_pkg::WAIT_LOW: begin
        if (!gimme) state_nxt = sha3_pkg::IDLE;
      end
      default: state_nxt = sha3_pkg::IDLE;
    endcase
  end

  assign pop = load & load_real;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot   <= '0;
      n_real <= '0;
      timer  <= '0;
    end else begin
      if (state == sha3_pkg::IDLE) begin
        slot <= '0;
        if (start) n_real <= clamp_to_burst(count);
      end else if (state == sha3_pkg::BURST) begin
        slot <= slot + 1'b1;
      end
      if (state != sha3_pkg::IDLE || empty || start) timer <= '0;
      else if (count < CNT_W'(BURST))                timer <= sat_inc(timer);
    end
  end

  // ---- stage p0: slot presented to the pipe ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_p0 <= 1'b0;
      real_p0   <= 1'b0;
      out_p0    <= '0;
    end else if (load) begin
      sample_p0 <= 1'b1;
      real_p0   <= load_real;
      out_p0    <= load_real ? head : '0;
    end else begin
      sample_p0 <= 1'b0;
    end
  end

  assign sample   = sample_p0;
  assign out_real = real_p0;
  assign {out_tag, oe, od, oc, ob, oa} = out_p0;

endmodule

// File: tb/tb_sha3_burst_feeder.sv
// Randomized bench for sha3_burst_feeder with a queue-based reference model.
module tb_sha3_burst_feeder;

  localparam int BURST   = 16;
  localparam int DEPTH   = 32;
  localparam int TAG_W   = 8;
  localparam int TIMEOUT = 256;

  typedef logic [1599+TAG_W:0] word_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [319:0]     ina = '0, inb = '0, inc = '0, ind = '0, ine = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             gimme = 1'b0;
  logic             sample;
  logic [319:0]     oa, ob, oc, od, oe;
  logic [TAG_W-1:0] out_tag;
  logic             out_real;

  int checks = 0;
  int failures = 0;

  word_t mq[$];
  int    edge_cnt = 0;
  int    rise_edge = 0;
  int    fall_edge = 0;
  int    slot = 0;
  int    nreal = 0;
  int    burst_reals = 0;
  bit    rose = 0;
  bit    fell = 0;
  bit    in_burst = 0;
  bit    last_acc = 0;
  logic [TAG_W-1:0] tag_ctr = '0;

  sha3_burst_feeder #(
    .BURST(BURST), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ina(ina), .inb(inb), .inc(inc), .ind(ind), .ine(ine), .in_tag(in_tag),
    .gimme(gimme), .sample(sample),
    .oa(oa), .ob(ob), .oc(oc), .od(od), .oe(oe),
    .out_tag(out_tag), .out_real(out_real)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Any single flipped bit anywhere in the 25 lanes changes this value.
  function automatic logic [63:0] fold(input logic [1599:0] s);
    logic [63:0] r = '0;
    logic [63:0] lane;
    for (int i = 0; i < 25; i++) begin
      lane = s[i*64 +: 64];
      r ^= (lane << i) | (lane >> (64 - i));
    end
    return r;
  endfunction

  function automatic logic [319:0] rnd_row();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input logic [TAG_W-1:0] tag);
    in_tag = tag;
    ina = rnd_row();
    ina[63:0] = 64'(tag);
    inb = rnd_row();
    inc = rnd_row();
    ind = rnd_row();
    ine = rnd_row();
  endtask

  // One clock: update the model from what the DUT saw before the edge, then
  // check every output presented after it.
  task automatic tick();
    bit    acc;
    int    pre;
    word_t ent;
    word_t e;
    acc = in_valid && in_ready && rst_n;
    pre = mq.size();
    ent = {in_tag, ine, ind, inc, inb, ina};
    @(posedge clk);
    #1;
    edge_cnt++;
    rose = 0;
    fell = 0;
    last_acc = acc;
    if (!rst_n) begin
      mq.delete();
      in_burst = 0;
      last_acc = 0;
      return;
    end
    if (sample) begin
      if (!in_burst) begin
        in_burst = 1;
        slot = 0;
        nreal = (pre < BURST) ? pre : BURST;
        burst_reals = 0;
        rose = 1;
        rise_edge = edge_cnt;
      end else begin
        slot++;
      end
      if (slot < nreal) begin
        e = mq.pop_front();
        check("slot_real", 64'(out_real), 64'd1);
        check("slot_tag", 64'(out_tag), 64'(e[1599+TAG_W:1600]));
        check("slot_data", fold({oe, od, oc, ob, oa}), fold(e[1599:0]));
        burst_reals++;
      end else begin
        check("pad_real", 64'(out_real), 64'd0);
        check("pad_tag", 64'(out_tag), 64'd0);
        check("pad_data", fold({oe, od, oc, ob, oa}), 64'd0);
      end
    end else if (in_burst) begin
      in_burst = 0;
      fell = 1;
      fall_edge = edge_cnt;
      check("burst_len", 64'(slot + 1), 64'(BURST));
    end
    if (acc) mq.push_back(ent);
    check("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
  endtask

  task automatic push_one(input logic [TAG_W-1:0] tag, output int edge_at);
    int n = 0;
    drive(tag);
    in_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 100);
    if (!last_acc) check("push_timeout", 64'd0, 64'd1);
    edge_at = edge_cnt;
    in_valid = 1'b0;
  endtask

  task automatic push_many(input int n, input bit gaps, output int first_edge, output int last_edge);
    int e;
    for (int i = 0; i < n; i++) begin
      push_one(tag_ctr, e);
      tag_ctr++;
      if (i == 0) first_edge = e;
      last_edge = e;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic wait_rise(input int bound);
    int n = 0;
    while (!rose && n < bound) begin
      tick();
      n++;
    end
    if (!rose) check("wait_rise_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_fall(input int bound);
    int n = 0;
    while (in_burst && n < bound) begin
      tick();
      n++;
    end
    if (in_burst) check("wait_fall_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int guard = 0;
    wait_fall(40);
    while (mq.size() > 0 && guard < 6) begin
      gimme = 1'b0;
      tick();
      gimme = 1'b1;
      wait_rise(400);
      wait_fall(40);
      guard++;
    end
    check("drain_empty", 64'(mq.size()), 64'd0);
    gimme = 1'b0;
    tick();
  endtask

  initial begin
    int p_first, p_last, acc_cnt, n;

    // Reset values
    rst_n = 1'b0;
    #12;
    check("rst_sample", 64'(sample), 64'd0);
    check("rst_real", 64'(out_real), 64'd0);
    check("rst_tag", 64'(out_tag), 64'd0);
    check("rst_oa", oa[63:0], 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Full burst with gimme high: tags 0..15 in order
    gimme = 1'b1;
    tag_ctr = '0;
    push_many(16, 0, p_first, p_last);
    wait_rise(40);
    check("s1_latency", 64'(rise_edge - p_last), 64'd1);
    wait_fall(40);
    check("s1_len_edges", 64'(fall_edge - rise_edge), 64'(BURST));
    check("s1_reals", 64'(burst_reals), 64'(BURST));
    check("s1_empty", 64'(mq.size()), 64'd0);

    // Queued burst held off while gimme is low
    gimme = 1'b0;
    tick();
    push_many(16, 1, p_first, p_last);
    for (int i = 0; i < 50; i++) begin
      tick();
      check("s2_hold", 64'(sample), 64'd0);
    end
    gimme = 1'b1;
    tick();
    check("s2_start", 64'(rose), 64'd1);
    wait_fall(40);
    check("s2_reals", 64'(burst_reals), 64'(BURST));

    // Partial burst launched by the idle timeout
    gimme = 1'b0;
    tick();
    gimme = 1'b1;
    push_many(5, 0, p_first, p_last);
    wait_rise(400);
    check("s3_timeout", 64'(rise_edge - p_first), 64'(TIMEOUT + 1));
    wait_fall(40);
    check("s3_reals", 64'(burst_reals), 64'd5);

    // FIFO full backpressure, then release by a burst
    gimme = 1'b0;
    tick();
    acc_cnt = 0;
    n = 0;
    drive(tag_ctr);
    in_valid = 1'b1;
    while (acc_cnt < DEPTH && n < 200) begin
      tick();
      n++;
      if (last_acc) begin
        acc_cnt++;
        tag_ctr++;
        drive(tag_ctr);
      end
    end
    check("s4_accepted", 64'(acc_cnt), 64'(DEPTH));
    repeat (3) tick();
    check("s4_blocked", 64'(last_acc), 64'd0);
    check("s4_ready_low", 64'(in_ready), 64'd0);
    gimme = 1'b1;
    tick();
    check("s4_rise", 64'(rose), 64'd1);
    check("s4_ready_up", 64'(in_ready), 64'd1);
    tick();
    check("s4_acc33", 64'(last_acc), 64'd1);
    tag_ctr++;
    in_valid = 1'b0;
    drain();

    // 40 states, gimme held past the burst end, then low-then-high
    push_many(DEPTH, 0, p_first, p_last);
    gimme = 1'b1;
    tick();
    check("s5_rise1", 64'(rose), 64'd1);
    push_many(8, 0, p_first, p_last);
    wait_fall(40);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s5_hold_high", 64'(sample), 64'd0);
    end
    gimme = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("s5_hold_low", 64'(sample), 64'd0);
    end
    gimme = 1'b1;
    tick();
    check("s5_rise2", 64'(rose), 64'd1);
    wait_fall(40);
    check("s5_reals2", 64'(burst_reals), 64'(BURST));
    gimme = 1'b0;
    tick();
    gimme = 1'b1;
    wait_rise(400);
    wait_fall(40);
    check("s5_reals3", 64'(burst_reals), 64'd8);
    check("s5_empty", 64'(mq.size()), 64'd0);

    // Asynchronous reset during slot 7 discards everything queued
    gimme = 1'b0;
    tick();
    push_many(20, 0, p_first, p_last);
    gimme = 1'b1;
    wait_rise(10);
    n = 0;
    while (slot != 7 && n < 20) begin
      tick();
      n++;
    end
    check("s6_slot7", 64'(slot), 64'd7);
    #3;
    rst_n = 1'b0;
    #1;
    check("s6_rst_sample", 64'(sample), 64'd0);
    check("s6_rst_real", 64'(out_real), 64'd0);
    check("s6_rst_ready", 64'(in_ready), 64'd1);
    mq.delete();
    in_burst = 0;
    gimme = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("s6_ready_after", 64'(in_ready), 64'd1);
    gimme = 1'b1;
    push_many(16, 0, p_first, p_last);
    wait_rise(40);
    check("s6_latency", 64'(rise_edge - p_last), 64'd1);
    wait_fall(40);
    check("s6_reals", 64'(burst_reals), 64'(BURST));
    check("s6_empty", 64'(mq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
